aur_tx_pkt_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one Aurora transmit queue among NUM_PORTS upstream output-queue requesters.
- Runs in the core clock domain (clk).
- Each input port has a small buffer. The block grants one port at a time, holds the grant until that packet's end-of-packet word is forwarded, then rotates priority.
- Its out_* bus drives the Aurora tx queue's in_data/in_ctrl/in_wr/in_rdy interface directly.

---
 rtl/aur_tx_pkt_arbiter_pkg.sv | 24 ++
 rtl/aur_tx_pkt_arbiter_if.sv | 40 ++++
 rtl/aur_arb_in_fifo.sv | 92 +++++++++
 rtl/aur_tx_pkt_arbiter.sv | 167 ++++++++++++++++
 tb/tb_aur_tx_pkt_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aur_tx_pkt_arbiter_pkg.sv
// Shared arbiter definitions: one-hot FSM state encodings, default buffer
// depth and a small index helper.
//
// Contents:
//   arb_state_e          IDLE = 2'b01, XFER = 2'b10 (one-hot)
//   DEF_FIFO_DEPTH_BITS  log2 of the default per-port buffer depth
//   wrap_inc()           index + 1 modulo a port count
package aur_tx_pkt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_XFER = 2'b10
  } arb_state_e;

  localparam int unsigned DEF_DATA_WIDTH      = 64;
  localparam int unsigned DEF_NUM_PORTS       = 4;
  localparam int unsigned DEF_FIFO_DEPTH_BITS = 3;

  // Next index with wrap-around at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/aur_tx_pkt_arbiter_if.sv
// Bus bundle between the upstream output-queue requesters, the arbiter and
// the Aurora tx queue.
//
// Signals:
//   in_data  [NUM_PORTS*DATA_WIDTH]  per-port words, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_ctrl  [NUM_PORTS*CTRL_WIDTH]  per-port ctrl,  port p at [p*CTRL_WIDTH +: CTRL_WIDTH]
//   in_wr    [NUM_PORTS]             per-port write strobe
//   in_rdy   [NUM_PORTS]             per-port buffer has room (<= depth-2 words)
//   out_data [DATA_WIDTH]            word to tx queue
//   out_ctrl [CTRL_WIDTH]            ctrl to tx queue
//   out_wr                           write strobe to tx queue
//   out_rdy                          tx queue not almost full
//   grant    [NUM_PORTS]             one-hot current owner, 0 when idle
// Modports: master = requesters/tx-queue side, slave = arbiter.
interface aur_tx_pkt_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_PORTS  = 4
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS*CTRL_WIDTH-1:0] in_ctrl;
  logic [NUM_PORTS-1:0]            in_wr;
  logic [NUM_PORTS-1:0]            in_rdy;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [CTRL_WIDTH-1:0]           out_ctrl;
  logic                            out_wr;
  logic                            out_rdy;
  logic [NUM_PORTS-1:0]            grant;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr, grant
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr, grant
  );

endinterface

// File: rtl/aur_arb_in_fifo.sv
// Per-port synchronous fall-through buffer for the packet arbiter.
// The head word is visible on rd_data_c while the buffer is non-empty.
//
// Ports:
//   clk, reset   core clock, synchronous active-high reset (flushes buffer)
//   wr_en/wr_data  write side; a write to a full buffer is dropped
//   rd_en          pop the head word (ignored when empty)
//   rd_data_c      head word (combinational from storage)
//   empty, full, count  occupancy status
//   prog_rdy       registered, high while occupancy <= depth-2
module aur_arb_in_fifo
  import aur_tx_pkt_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 72,
  parameter int unsigned DEPTH_BITS = DEF_FIFO_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data_c,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_BITS:0]   count,
  output logic                  prog_rdy
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CNT_W = DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] PROG_THRESH = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q;
  logic [DEPTH_BITS-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt_c;
  logic                  prog_rdy_q;
  logic                  wr_ok_c;
  logic                  rd_ok_c;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign prog_rdy  = prog_rdy_q;
  assign rd_data_c = mem_q[rd_ptr_q];

  assign wr_ok_c = wr_en && !full;
  assign rd_ok_c = rd_en && !empty;

  // Occupancy after this cycle's write/pop.
  always_comb begin
    count_nxt_c = count_q;
    if (wr_ok_c && !rd_ok_c) begin
      count_nxt_c = count_q + CNT_W'(1);
    end else if (!wr_ok_c && rd_ok_c) begin
      count_nxt_c = count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prog_rdy_q <= 1'b1;
    end else begin
      if (wr_ok_c) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
      end
      if (rd_ok_c) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
      end
      count_q    <= count_nxt_c;
      prog_rdy_q <= (count_nxt_c <= PROG_THRESH);
    end
  end

  // A write into a full buffer loses the word.
  overflow_chk: assert property (@(posedge clk) disable iff (reset) !(wr_en && full))
    else $error("aur_arb_in_fifo: write to full buffer, word dropped");

endmodule

// File: rtl/aur_tx_pkt_arbiter.sv
// Packet-granular arbiter sharing one Aurora tx queue among NUM_PORTS
// upstream requesters. Each port has a small fall-through buffer; one port
// is granted at a time and keeps the grant until its end-of-packet word is
// forwarded. Framing per port: ctrl!=0 outside a packet is a header,
// ctrl==0 is data (enters packet), ctrl!=0 inside a packet is EOP.
//
// Build option: define AUR_ARB_STRICT_PRIO_EN to make every idle scan start
// at port 0 (lowest index wins) instead of round-robin.
//
// Ports:
//   clk    core clock
//   reset  synchronous, active-high
//   bus    aur_tx_pkt_arbiter_if.slave: in_data/in_ctrl/in_wr/in_rdy per
//          port, registered out_data/out_ctrl/out_wr, out_rdy, one-hot grant
module aur_tx_pkt_arbiter
  import aur_tx_pkt_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned NUM_PORTS       = DEF_NUM_PORTS,
  parameter int unsigned FIFO_DEPTH_BITS = DEF_FIFO_DEPTH_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  aur_tx_pkt_arbiter_if.slave  bus
);

  localparam int unsigned WORD_W = DATA_WIDTH + CTRL_WIDTH;
  localparam int unsigned IDX_W  = $clog2(NUM_PORTS);
  localparam int unsigned CNT_W  = FIFO_DEPTH_BITS + 1;

  logic [NUM_PORTS-1:0][WORD_W-1:0] fifo_rd_c;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  fifo_count;
  logic [NUM_PORTS-1:0]             fifo_empty;
  logic [NUM_PORTS-1:0]             fifo_full;
  logic [NUM_PORTS-1:0]             fifo_prog_rdy;
  logic [NUM_PORTS-1:0]             fifo_rd_en_c;
  logic                             unused_fifo_status_c;

  arb_state_e            state_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [IDX_W-1:0]      gidx_q;
  logic [NUM_PORTS-1:0]  in_pkt_q;
  logic                  out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  logic [IDX_W-1:0]      scan_start_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic                  win_vld_c;
  logic [WORD_W-1:0]     cur_word_c;
  logic [CTRL_WIDTH-1:0] cur_ctrl_c;
  logic                  pop_c;
  logic                  eop_c;

  // Per-port input buffers.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in_fifo
    aur_arb_in_fifo #(
      .WIDTH      (WORD_W),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (bus.in_wr[p]),
      .wr_data   ({bus.in_ctrl[p*CTRL_WIDTH +: CTRL_WIDTH],
                   bus.in_data[p*DATA_WIDTH +: DATA_WIDTH]}),
      .rd_en     (fifo_rd_en_c[p]),
      .rd_data_c (fifo_rd_c[p]),
      .empty     (fifo_empty[p]),
      .full      (fifo_full[p]),
      .count     (fifo_count[p]),
      .prog_rdy  (fifo_prog_rdy[p])
    );
  end

  // Occupancy detail is not needed by the arbiter itself.
  assign unused_fifo_status_c = ^{fifo_full, fifo_count};

`ifdef AUR_ARB_STRICT_PRIO_EN
  assign scan_start_c = '0;
`else
  logic [IDX_W-1:0] ptr_q;
  assign scan_start_c = ptr_q;
`endif

  // First non-empty port at or above scan_start_c, with wrap-around.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      cand = IDX_W'((32'(scan_start_c) + 32'(i)) % NUM_PORTS);
      if (!fifo_empty[cand]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand;
      end
    end
  end

  assign cur_word_c = fifo_rd_c[gidx_q];
  assign cur_ctrl_c = cur_word_c[DATA_WIDTH +: CTRL_WIDTH];
  assign pop_c      = (state_q == ST_XFER) && !fifo_empty[gidx_q] && bus.out_rdy;
  assign eop_c      = pop_c && (cur_ctrl_c != '0) && in_pkt_q[gidx_q];

  // Only the granted buffer is ever popped.
  always_comb begin
    fifo_rd_en_c         = '0;
    fifo_rd_en_c[gidx_q] = pop_c;
  end

  // Arbiter FSM, framing state, pointer and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      in_pkt_q   <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
`ifndef AUR_ARB_STRICT_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      out_wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_vld_c) begin
            state_q <= ST_XFER;
            gidx_q  <= win_idx_c;
            grant_q <= NUM_PORTS'(1) << win_idx_c;
          end
        end
        ST_XFER: begin
          if (pop_c) begin
            out_wr_q   <= 1'b1;
            out_data_q <= cur_word_c[DATA_WIDTH-1:0];
            out_ctrl_q <= cur_ctrl_c;
            if (eop_c) begin
              in_pkt_q[gidx_q] <= 1'b0;
              state_q          <= ST_IDLE;
              grant_q          <= '0;
`ifndef AUR_ARB_STRICT_PRIO_EN
              ptr_q            <= IDX_W'(wrap_inc(32'(gidx_q), NUM_PORTS));
`endif
            end else if (cur_ctrl_c == '0) begin
              in_pkt_q[gidx_q] <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.in_rdy   = fifo_prog_rdy;
  assign bus.out_data = out_data_q;
  assign bus.out_ctrl = out_ctrl_q;
  assign bus.out_wr   = out_wr_q;
  assign bus.grant    = grant_q;

endmodule

// File: tb/tb_aur_tx_pkt_arbiter.sv
// Directed testbench for aur_tx_pkt_arbiter (4 ports, 64-bit data).
// Honours AUR_ARB_STRICT_PRIO_EN for the arbitration-order expectations.
module tb_aur_tx_pkt_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned NP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  aur_tx_pkt_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_PORTS(NP)) bus ();

  aur_tx_pkt_arbiter #(
    .DATA_WIDTH      (DW),
    .CTRL_WIDTH      (CW),
    .NUM_PORTS       (NP),
    .FIFO_DEPTH_BITS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Output capture: every out_wr word with the cycle it appeared in.
  logic [DW-1:0] cap_data [$];
  logic [CW-1:0] cap_ctrl [$];
  int            cap_cyc  [$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.out_wr === 1'b1) begin
      cap_data.push_back(bus.out_data);
      cap_ctrl.push_back(bus.out_ctrl);
      cap_cyc.push_back(cyc);
    end
  end

  // Expected word for the bench encoding: port in the top byte, tag in the low bits.
  function automatic logic [DW-1:0] mkw(input int p, input int k);
    return (64'(p) << 56) | 64'(k);
  endfunction

  // Ctrl for word k of an n-word packet: header, data..., EOP.
  function automatic logic [CW-1:0] ctl(input int k, input int n);
    if (k == 0) return 8'hFF;
    if (k == n - 1) return 8'h01;
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_wr();
    bus.in_wr = '0;
  endtask

  task automatic put(input int p, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_wr[p]            = 1'b1;
    bus.in_data[p*DW +: DW] = d;
    bus.in_ctrl[p*CW +: CW] = c;
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_ctrl.delete();
    cap_cyc.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clr_wr();
    bus.out_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    clear_cap();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_wr();
    bus.out_rdy = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.out_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_out_wr: got %0b want 0", bus.out_wr); end
    tests_run++;
    if (bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    tests_run++;
    if (bus.out_data !== 64'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    tests_run++;
    if (bus.out_ctrl !== 8'h00) begin tests_failed++; $display("FAIL reset_out_ctrl: got %h want 00", bus.out_ctrl); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (bus.in_rdy !== 4'b1111) begin tests_failed++; $display("FAIL reset_in_rdy: got %b want 1111", bus.in_rdy); end
    tick();
    tests_run++;
    if (bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL idle_empty_grant: got %b want 0000", bus.grant); end
    clear_cap();
  endtask

  task automatic test_single_packet();
    logic [3:0] exp_g;
    logic [DW-1:0] ed [$];
    logic [CW-1:0] ec [$];
    for (int t = 1; t <= 10; t++) begin
      clr_wr();
      if (t <= 4) put(2, ctl(t - 1, 4), mkw(2, t - 1));
      tick();
      exp_g = (t >= 2 && t <= 5) ? 4'b0100 : 4'b0000;
      if (t <= 8) begin
        tests_run++;
        if (bus.grant !== exp_g) begin tests_failed++; $display("FAIL single_grant t=%0d: got %b want %b", t, bus.grant, exp_g); end
      end
    end
    for (int k = 0; k < 4; k++) begin ed.push_back(mkw(2, k)); ec.push_back(ctl(k, 4)); end
    tests_run++;
    if (cap_data.size() != 4) begin tests_failed++; $display("FAIL single_count: got %0d want 4", cap_data.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= cap_data.size()) begin tests_failed++; $display("FAIL single_word %0d: missing want %h/%h", i, ed[i], ec[i]); end
      else if (cap_data[i] !== ed[i] || cap_ctrl[i] !== ec[i]) begin
        tests_failed++; $display("FAIL single_word %0d: got %h/%h want %h/%h", i, cap_data[i], cap_ctrl[i], ed[i], ec[i]);
      end
      if (i > 0 && i < cap_cyc.size()) begin
        tests_run++;
        if (cap_cyc[i] - cap_cyc[i-1] != 1) begin tests_failed++; $display("FAIL single_rate %0d: gap %0d want 1", i, cap_cyc[i] - cap_cyc[i-1]); end
      end
    end
    // Pointer now 3: ports 0 and 3 loaded together.
    clear_cap();
    ed.delete();
    ec.delete();
    for (int t = 1; t <= 14; t++) begin
      clr_wr();
      if (t <= 3) begin
        put(0, ctl(t - 1, 3), mkw(0, 8 + t - 1));
        put(3, ctl(t - 1, 3), mkw(3, 8 + t - 1));
      end
      tick();
    end
`ifdef AUR_ARB_STRICT_PRIO_EN
    for (int k = 0; k < 3; k++) begin ed.push_back(mkw(0, 8 + k)); ec.push_back(ctl(k, 3)); end
    for (int k = 0; k < 3; k++) begin ed.push_back(mkw(3, 8 + k)); ec.push_back(ctl(k, 3)); end
`else
    for (int k = 0; k < 3; k++) begin ed.push_back(mkw(3, 8 + k)); ec.push_back(ctl(k, 3)); end
    for (int k = 0; k < 3; k++) begin ed.push_back(mkw(0, 8 + k)); ec.push_back(ctl(k, 3)); end
`endif
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i >= cap_data.size()) begin tests_failed++; $display("FAIL ptr_word %0d: missing want %h", i, ed[i]); end
      else if (cap_data[i] !== ed[i] || cap_ctrl[i] !== ec[i]) begin
        tests_failed++; $display("FAIL ptr_word %0d: got %h/%h want %h/%h", i, cap_data[i], cap_ctrl[i], ed[i], ec[i]);
      end
    end
    clear_cap();
  endtask

  task automatic test_all_ports();
    logic [DW-1:0] ed [$];
    int exp_gap;
    apply_reset();
    for (int t = 1; t <= 24; t++) begin
      clr_wr();
      if (t <= 3) for (int p = 0; p < 4; p++) put(p, ctl(t - 1, 3), mkw(p, 16 + t - 1));
      tick();
    end
    for (int p = 0; p < 4; p++) for (int k = 0; k < 3; k++) ed.push_back(mkw(p, 16 + k));
    tests_run++;
    if (cap_data.size() != 12) begin tests_failed++; $display("FAIL all_count: got %0d want 12", cap_data.size()); end
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (i >= cap_data.size()) begin tests_failed++; $display("FAIL all_word %0d: missing want %h", i, ed[i]); end
      else if (cap_data[i] !== ed[i] || cap_ctrl[i] !== ctl(i % 3, 3)) begin
        tests_failed++; $display("FAIL all_word %0d: got %h/%h want %h/%h", i, cap_data[i], cap_ctrl[i], ed[i], ctl(i % 3, 3));
      end
      if (i > 0 && i < cap_cyc.size()) begin
        exp_gap = (i % 3 == 0) ? 2 : 1;
        tests_run++;
        if (cap_cyc[i] - cap_cyc[i-1] != exp_gap) begin
          tests_failed++; $display("FAIL all_gap %0d: got %0d want %0d", i, cap_cyc[i] - cap_cyc[i-1], exp_gap);
        end
      end
    end
    clear_cap();
  endtask

  task automatic test_stall();
    logic [DW-1:0] ed [$];
    logic [CW-1:0] ec [$];
    for (int t = 1; t <= 20; t++) begin
      clr_wr();
      if (t == 1)  put(1, 8'hFF, mkw(1, 32));
      if (t == 2)  put(1, 8'h00, mkw(1, 33));
      if (t == 9)  put(1, 8'h00, mkw(1, 34));
      if (t == 10) put(1, 8'h01, mkw(1, 35));
      if (t <= 3)  put(3, ctl(t - 1, 3), mkw(3, 32 + t - 1));
      tick();
      if (t >= 5 && t <= 9) begin
        tests_run++;
        if (bus.out_wr !== 1'b0) begin tests_failed++; $display("FAIL stall_out_wr t=%0d: got %0b want 0", t, bus.out_wr); end
        tests_run++;
        if (bus.grant !== 4'b0010) begin tests_failed++; $display("FAIL stall_grant t=%0d: got %b want 0010", t, bus.grant); end
      end
    end
    for (int k = 0; k < 4; k++) begin ed.push_back(mkw(1, 32 + k)); ec.push_back(ctl(k, 4)); end
    for (int k = 0; k < 3; k++) begin ed.push_back(mkw(3, 32 + k)); ec.push_back(ctl(k, 3)); end
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (i >= cap_data.size()) begin tests_failed++; $display("FAIL stall_word %0d: missing want %h", i, ed[i]); end
      else if (cap_data[i] !== ed[i] || cap_ctrl[i] !== ec[i]) begin
        tests_failed++; $display("FAIL stall_word %0d: got %h/%h want %h/%h", i, cap_data[i], cap_ctrl[i], ed[i], ec[i]);
      end
    end
    clear_cap();
  endtask

  task automatic test_backpressure();
    int wi = 0;
    for (int t = 1; t <= 45; t++) begin
      bus.out_rdy = !(t >= 5 && t <= 14);
      clr_wr();
      if (wi < 12 && bus.in_rdy[0] === 1'b1) begin
        put(0, ctl(wi, 12), mkw(0, 48 + wi));
        wi++;
      end
      tick();
      if (t >= 5 && t <= 14) begin
        tests_run++;
        if (bus.out_wr !== 1'b0) begin tests_failed++; $display("FAIL bp_out_wr t=%0d: got %0b want 0", t, bus.out_wr); end
      end
      if (t == 8) begin
        tests_run++;
        if (bus.in_rdy[0] !== 1'b1) begin tests_failed++; $display("FAIL bp_in_rdy_6: got %0b want 1", bus.in_rdy[0]); end
      end
      if (t == 9) begin
        tests_run++;
        if (bus.in_rdy[0] !== 1'b0) begin tests_failed++; $display("FAIL bp_in_rdy_7: got %0b want 0", bus.in_rdy[0]); end
      end
    end
    bus.out_rdy = 1'b1;
    tests_run++;
    if (cap_data.size() != 12) begin tests_failed++; $display("FAIL bp_count: got %0d want 12", cap_data.size()); end
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (i >= cap_data.size()) begin tests_failed++; $display("FAIL bp_word %0d: missing want %h", i, mkw(0, 48 + i)); end
      else if (cap_data[i] !== mkw(0, 48 + i) || cap_ctrl[i] !== ctl(i, 12)) begin
        tests_failed++; $display("FAIL bp_word %0d: got %h/%h want %h/%h", i, cap_data[i], cap_ctrl[i], mkw(0, 48 + i), ctl(i, 12));
      end
    end
    clear_cap();
  endtask

  task automatic test_reset_mid_packet();
    for (int t = 1; t <= 4; t++) begin
      clr_wr();
      put(1, ctl(t - 1, 6), mkw(1, 64 + t - 1));
      tick();
    end
    clr_wr();
    reset = 1'b1;
    tick();
    tests_run++;
    if (bus.out_wr !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out_wr: got %0b want 0", bus.out_wr); end
    tests_run++;
    if (bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL rst_mid_grant: got %b want 0000", bus.grant); end
    tests_run++;
    if (bus.in_rdy !== 4'b1111) begin tests_failed++; $display("FAIL rst_mid_in_rdy: got %b want 1111", bus.in_rdy); end
    tests_run++;
    if (cap_data.size() != 2) begin tests_failed++; $display("FAIL rst_mid_partial: got %0d words want 2", cap_data.size()); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (bus.in_rdy !== 4'b1111) begin tests_failed++; $display("FAIL rst_after_in_rdy: got %b want 1111", bus.in_rdy); end
    clear_cap();
    for (int t = 1; t <= 12; t++) begin
      clr_wr();
      if (t <= 3) put(0, ctl(t - 1, 3), mkw(0, 72 + t - 1));
      tick();
    end
    tests_run++;
    if (cap_data.size() != 3) begin tests_failed++; $display("FAIL rst_fresh_count: got %0d want 3", cap_data.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= cap_data.size()) begin tests_failed++; $display("FAIL rst_fresh_word %0d: missing want %h", i, mkw(0, 72 + i)); end
      else if (cap_data[i] !== mkw(0, 72 + i) || cap_ctrl[i] !== ctl(i, 3)) begin
        tests_failed++; $display("FAIL rst_fresh_word %0d: got %h/%h want %h/%h", i, cap_data[i], cap_ctrl[i], mkw(0, 72 + i), ctl(i, 3));
      end
    end
    clear_cap();
  endtask

  // Port 0 carries two packets, port 3 one; the pointer starts at 1.
  task automatic test_priority();
    logic [DW-1:0] ed [$];
    for (int t = 1; t <= 20; t++) begin
      clr_wr();
      if (t <= 6) put(0, ctl((t - 1) % 3, 3), mkw(0, 80 + t - 1));
      if (t <= 3) put(3, ctl(t - 1, 3), mkw(3, 96 + t - 1));
      tick();
    end
`ifdef AUR_ARB_STRICT_PRIO_EN
    for (int k = 0; k < 6; k++) ed.push_back(mkw(0, 80 + k));
    for (int k = 0; k < 3; k++) ed.push_back(mkw(3, 96 + k));
`else
    for (int k = 0; k < 3; k++) ed.push_back(mkw(3, 96 + k));
    for (int k = 0; k < 6; k++) ed.push_back(mkw(0, 80 + k));
`endif
    tests_run++;
    if (cap_data.size() != 9) begin tests_failed++; $display("FAIL prio_count: got %0d want 9", cap_data.size()); end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (i >= cap_data.size()) begin tests_failed++; $display("FAIL prio_word %0d: missing want %h", i, ed[i]); end
      else if (cap_data[i] !== ed[i]) begin
        tests_failed++; $display("FAIL prio_word %0d: got %h want %h", i, cap_data[i], ed[i]);
      end
    end
    clear_cap();
  endtask

  initial begin
    bus.in_wr   = '0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    bus.out_rdy = 1'b1;
    test_reset();
    test_single_packet();
    test_all_ports();
    test_stall();
    test_backpressure();
    test_reset_mid_packet();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
